// File: rtl/gb_interrupt_ctrl_pkg.sv
// Shared constants and types for the interrupt controller slice.
package gb_int_pkg;

    localparam int unsigned INT_VBLANK = 0;
    localparam int unsigned INT_STAT   = 1;
    localparam int unsigned INT_TIMER  = 2;
    localparam int unsigned INT_SERIAL = 3;
    localparam int unsigned INT_JOYPAD = 4;

    localparam int unsigned NUM_SRC_DEF    = 5;
    localparam logic [7:0]  VEC_BASE_DEF   = 8'h40;
    localparam int unsigned VEC_STRIDE_DEF = 8;

    typedef enum logic {
        IDLE,
        RESOLVE
    } int_state_t;

endpackage

// File: rtl/gb_interrupt_ctrl_if.sv
// CPU-side register bus and dispatch handshake of the interrupt controller.
interface gb_interrupt_ctrl_if;

    logic       cpu_sel_if;
    logic       cpu_sel_ie;
    logic       cpu_wr;
    logic [7:0] cpu_di;
    logic [7:0] cpu_do;
    logic       int_req;
    logic       int_ack;
    logic [7:0] int_vec;
    logic       int_vec_valid;

    modport master (
        output cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, int_ack,
        input  cpu_do, int_req, int_vec, int_vec_valid
    );

    modport slave (
        input  cpu_sel_if, cpu_sel_ie, cpu_wr, cpu_di, int_ack,
        output cpu_do, int_req, int_vec, int_vec_valid
    );

endinterface

// File: rtl/gb_int_prio_enc.sv
// Lowest-set-bit encoder: bit 0 has the highest priority.
module gb_int_prio_enc #(
    parameter int unsigned NUM_SRC = 5,
    parameter int unsigned IW      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic [NUM_SRC-1:0] req,
    output logic               valid,
    output logic [IW-1:0]      index
);

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (req[i] && !valid) begin
                valid = 1'b1;
                index = IW'(i);
            end
        end
    end

endmodule

// File: rtl/gb_interrupt_ctrl.sv
// IF/IE registers, request edge capture and the ack -> vector dispatch FSM.
module gb_interrupt_ctrl
    import gb_int_pkg::*;
#(
    parameter int unsigned NUM_SRC    = NUM_SRC_DEF,
    parameter logic [7:0]  VEC_BASE   = VEC_BASE_DEF,
    parameter int unsigned VEC_STRIDE = VEC_STRIDE_DEF
) (
    input  logic               clk_sys,
    input  logic               reset,
    input  logic               ce,
    input  logic [NUM_SRC-1:0] irq_src,
    gb_interrupt_ctrl_if.slave bus
);

    localparam int unsigned IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    int_state_t         state_q, state_d;
    logic [NUM_SRC-1:0] if_q, if_d, src_q;
    logic [7:0]         ie_q, ie_d;
    logic [7:0]         vec_q, vec_d;
    logic               valid_q, valid_d;

    logic [NUM_SRC-1:0] rise, if_base, pend, clr_mask;
    logic               pend_valid;
    logic [IW-1:0]      pend_idx;
    logic [7:0]         if_rd;

    assign rise = irq_src & ~src_q;

    gb_int_prio_enc #(.NUM_SRC(NUM_SRC), .IW(IW)) u_prio (
        .req   (pend),
        .valid (pend_valid),
        .index (pend_idx)
    );

    // Resolution sees this ce's CPU writes; capture edges are OR'd in last so they beat the clear.
    always_comb begin
        if_base  = (bus.cpu_sel_if && bus.cpu_wr) ? bus.cpu_di[NUM_SRC-1:0] : if_q;
        ie_d     = (bus.cpu_sel_ie && bus.cpu_wr) ? bus.cpu_di : ie_q;
        pend     = ie_d[NUM_SRC-1:0] & if_base;
        clr_mask = '0;
        state_d  = state_q;
        vec_d    = vec_q;
        valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.int_ack) state_d = RESOLVE;
            end
            RESOLVE: begin
                state_d = IDLE;
                valid_d = 1'b1;
                if (pend_valid) begin
                    clr_mask[pend_idx] = 1'b1;
                    vec_d = VEC_BASE + 8'(VEC_STRIDE * 32'(pend_idx));
                end else begin
                    vec_d = 8'h00;
                end
            end
            default: state_d = IDLE;
        endcase
        if_d = (if_base & ~clr_mask) | rise;
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            if_q    <= '0;
            ie_q    <= '0;
            src_q   <= '0;
            vec_q   <= '0;
            valid_q <= 1'b0;
        end else if (ce) begin
            state_q <= state_d;
            if_q    <= if_d;
            ie_q    <= ie_d;
            src_q   <= irq_src;
            vec_q   <= vec_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        if_rd = '1;
        if_rd[NUM_SRC-1:0] = if_q;
    end

    assign bus.cpu_do        = bus.cpu_sel_if ? if_rd : (bus.cpu_sel_ie ? ie_q : 8'hFF);
    assign bus.int_req       = |(ie_q[NUM_SRC-1:0] & if_q);
    assign bus.int_vec       = vec_q;
    assign bus.int_vec_valid = valid_q;

endmodule
